// File: rtl/ram_stream_ctrl.sv
// Stream FIFO controller over an external dual-port RAM (port A write, port B registered read).
// Defining RAM_STREAM_STATUS_EN adds the level and sticky overflow status outputs.
//   state   | meaning
//   IDLE    | nothing to present, out_valid low
//   WAIT    | RAM port B fetching the word at rptr
//   PRESENT | word at rptr on out_data, out_valid high
module ram_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr_a,
    output logic [AW-1:0]    ram_addr_b,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out_b
`ifdef RAM_STREAM_STATUS_EN
    ,
    output logic [AW:0]      level,
    output logic             overflow
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT} state_t;

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          wr_acc;
    logic          rd_acc;

    assign full        = (count_q == DEPTH_C);
    assign in_ready    = !full;
    assign wr_acc      = in_valid && !full;
    assign rd_acc      = (state_q == S_PRESENT) && out_ready;

    assign ram_we      = wr_acc;
    assign ram_addr_a  = wptr_q;
    assign ram_data_in = in_data;
    assign ram_addr_b  = rptr_q;
    assign out_data    = ram_data_out_b;
    assign out_valid   = (state_q == S_PRESENT);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) wptr_d = wptr_q + AW'(1);
        if (rd_acc) rptr_d = rptr_q + AW'(1);
        if (wr_acc && !rd_acc) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // After a handshake the RAM needs one WAIT cycle to fetch the next word at the new rptr.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (count_q != '0) state_d = S_WAIT;
            S_WAIT:    state_d = S_PRESENT;
            S_PRESENT: if (out_ready) state_d = (count_d != '0) ? S_WAIT : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

`ifdef RAM_STREAM_STATUS_EN
    logic overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (in_valid && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign level    = count_q;
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Self-checking bench for ram_stream_ctrl with a behavioural dual-port RAM and a queue reference model.
// Status outputs are checked when RAM_STREAM_STATUS_EN is defined.
module tb_ram_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       ram_we;
    logic [2:0] ram_addr_a;
    logic [2:0] ram_addr_b;
    logic [7:0] ram_data_in;
    logic [7:0] ram_q;
`ifdef RAM_STREAM_STATUS_EN
    logic [3:0] level;
    logic       overflow;
`endif

    logic [7:0] mem [0:7];

    int checks = 0;
    int errors = 0;

    ram_stream_ctrl #(.WIDTH(8), .AW(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .ram_we         (ram_we),
        .ram_addr_a     (ram_addr_a),
        .ram_addr_b     (ram_addr_b),
        .ram_data_in    (ram_data_in),
        .ram_data_out_b (ram_q)
`ifdef RAM_STREAM_STATUS_EN
        ,
        .level          (level),
        .overflow       (overflow)
`endif
    );

    always #5 clk = ~clk;

    // Dual-port RAM: registered read, old data returned on same-address write.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr_a] <= ram_data_in;
        ram_q <= mem[ram_addr_b];
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
        checks++; if (ram_addr_a !== 3'd0 || ram_addr_b !== 3'd0) begin
            errors++; $display("FAIL reset_addr got a=%0d b=%0d exp 0 0", ram_addr_a, ram_addr_b);
        end
`ifdef RAM_STREAM_STATUS_EN
        checks++; if (level !== 4'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_status got level=%0d ovf=%b exp 0 0", level, overflow);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_addr_a !== 3'd0 || ram_data_in !== 8'hA5) begin
            errors++; $display("FAIL single_write got we=%b a=%0d d=%h exp 1 0 a5", ram_we, ram_addr_a, ram_data_in);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (c == 3) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
                    errors++; $display("FAIL single_present c%0d got v=%b d=%h exp 1 a5", c, out_valid, out_data);
                end
            end else begin
                checks++; if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL single_valid c%0d got %b exp 0", c, out_valid);
                end
            end
        end
        checks++; if (in_ready !== 1'b1 || ram_addr_b !== 3'd1) begin
            errors++; $display("FAIL single_after got rdy=%b b=%0d exp 1 1", in_ready, ram_addr_b);
        end
`ifdef RAM_STREAM_STATUS_EN
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_level got %0d exp 0", level); end
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_fill();
        int idx;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            #1;
            checks++; if (in_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr_a !== 3'(i)) begin
                errors++; $display("FAIL fill_write%0d got rdy=%b we=%b a=%0d exp 1 1 %0d", i, in_ready, ram_we, ram_addr_a, i);
            end
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h99;
        #1;
        checks++; if (in_ready !== 1'b0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL fill_full got rdy=%b we=%b exp 0 0", in_ready, ram_we);
        end
`ifdef RAM_STREAM_STATUS_EN
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_level got %0d exp 8", level); end
`endif
        @(negedge clk);
        in_valid = 1'b0;
        #1;
`ifdef RAM_STREAM_STATUS_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
`endif
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== 8'h10 + 8'(idx)) begin
                    errors++; $display("FAIL fill_drain%0d got %h exp %h", idx, out_data, 8'h10 + 8'(idx));
                end
                idx++;
            end
        end
        checks++; if (idx != 8) begin errors++; $display("FAIL fill_drain_count got %0d exp 8", idx); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL fill_empty got v=%b rdy=%b exp 0 1", out_valid, in_ready);
        end
`ifdef RAM_STREAM_STATUS_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_sticky got %b exp 1", overflow); end
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int wi;
        int ri;
        do_reset();
        wi = 0; ri = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && ri < 12; c++) begin
            @(negedge clk);
            in_valid = (wi < 12);
            in_data = 8'h20 + 8'(wi);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_full c%0d got rdy=%b exp 1", c, in_ready); end
            if (in_valid) begin
                checks++; if (ram_we !== 1'b1 || ram_addr_a !== 3'(wi)) begin
                    errors++; $display("FAIL wrap_write%0d got we=%b a=%0d exp 1 %0d", wi, ram_we, ram_addr_a, wi % 8);
                end
                wi++;
            end
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== 8'h20 + 8'(ri) || ram_addr_b !== 3'(ri)) begin
                    errors++; $display("FAIL wrap_read%0d got d=%h b=%0d exp %h %0d", ri, out_data, ram_addr_b, 8'h20 + 8'(ri), ri % 8);
                end
                ri++;
            end
        end
        checks++; if (ri != 12) begin errors++; $display("FAIL wrap_count got %0d exp 12", ri); end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h30 + 8'(i);
        end
        #1;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got v=%b exp 1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h30) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%h exp 1 30", c, out_valid, out_data);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h30) begin
            errors++; $display("FAIL bp_release got v=%b d=%h exp 1 30", out_valid, out_data);
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_gap got v=%b exp 0", out_valid); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin
            errors++; $display("FAIL bp_next got v=%b d=%h exp 1 31", out_valid, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h40 + 8'(i);
            #1;
            if (i == 3) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin
                    errors++; $display("FAIL mid_first got v=%b d=%h exp 1 40", out_valid, out_data);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ram_addr_a !== 3'd0 || ram_addr_b !== 3'd0) begin
            errors++; $display("FAIL mid_reset got v=%b rdy=%b a=%0d b=%0d exp 0 1 0 0", out_valid, in_ready, ram_addr_a, ram_addr_b);
        end
`ifdef RAM_STREAM_STATUS_EN
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        #1;
        checks++; if (ram_addr_a !== 3'd0 || ram_we !== 1'b1) begin
            errors++; $display("FAIL mid_write got a=%0d we=%b exp 0 1", ram_addr_a, ram_we);
        end
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end while (out_valid !== 1'b1 && n < 10);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h55 || n != 3) begin
            errors++; $display("FAIL mid_after got v=%b d=%h lat=%0d exp 1 55 3", out_valid, out_data, n);
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_only_one got v=%b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int  wp;
        int  rp;
        bit  ovf;
        bit  exp_ready;
        bit  acc;
        int  n;
        do_reset();
        wp = 0; rp = 0; ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 99) < ((c < 200) ? 25 : 70));
            #1;
            exp_ready = (q.size() < 8);
            acc = in_valid && exp_ready;
            checks++; if (in_ready !== exp_ready || ram_we !== acc) begin
                errors++; $display("FAIL rand_ready c%0d got rdy=%b we=%b exp %b %b", c, in_ready, ram_we, exp_ready, acc);
            end
            if (acc) begin
                checks++; if (ram_addr_a !== 3'(wp) || ram_data_in !== in_data) begin
                    errors++; $display("FAIL rand_waddr c%0d got a=%0d d=%h exp %0d %h", c, ram_addr_a, ram_data_in, wp % 8, in_data);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious c%0d got valid with empty model", c);
                end else if (out_data !== q[0] || ram_addr_b !== 3'(rp)) begin
                    errors++; $display("FAIL rand_data c%0d got d=%h b=%0d exp %h %0d", c, out_data, ram_addr_b, q[0], rp % 8);
                end
            end
`ifdef RAM_STREAM_STATUS_EN
            checks++; if (level !== 4'(q.size()) || overflow !== ovf) begin
                errors++; $display("FAIL rand_status c%0d got level=%0d ovf=%b exp %0d %b", c, level, overflow, q.size(), ovf);
            end
`endif
            if (out_valid === 1'b1 && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                rp++;
            end
            if (acc) begin
                q.push_back(in_data);
                wp++;
            end
            if (in_valid && !exp_ready) ovf = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 60) begin
            @(negedge clk); #1;
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== q[0]) begin
                    errors++; $display("FAIL rand_drain got %h exp %h", out_data, q[0]);
                end
                void'(q.pop_front());
            end
            n++;
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain_timeout left %0d exp 0", q.size()); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
